mac_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate unit; successor to the fixed 16-bit `ALU` MAC. Each valid input pair X·B is multiplied, then added into a wide accumulator. The unit supports configurable operand/accumulator widths, signed or unsigned mode, accumulator restart without reset, a term counter, and sticky overflow detection. It sits in the datapath wherever the original `ALU` did, with a `valid_out` strobe added for downstream consumers.

---
 rtl/mac_pipe.sv | 119 +++++++++++
 tb/tb_mac_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe.sv
// Two-stage pipelined multiply-accumulate with restart, term count and sticky overflow.
// Optional build macro MAC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module mac_pipe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 39,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              R,
    input  logic              valid_in,
    input  logic              first_in,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] B,
    output logic [ACC_W-1:0]  y,
    output logic              valid_out,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic              ovf
);

    localparam int PW  = 2 * DATA_W;
    localparam bit SGN = (SIGNED != 0);

    logic              x_ext;
    logic              b_ext;
    logic [PW-1:0]     x_w;
    logic [PW-1:0]     b_w;
    logic [PW-1:0]     prod;

    logic [PW-1:0]     p_q;
    logic              v1;
    logic              f1;

    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W:0]    sum_w;
    logic              ovf_now;
    logic [ACC_W-1:0]  sat_val;
    logic [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Operands are widened to the product width first, so the low PW
    // bits of the multiply are the exact signed or unsigned product.
    assign x_ext = SGN & X[DATA_W-1];
    assign b_ext = SGN & B[DATA_W-1];
    assign x_w   = {{DATA_W{x_ext}}, X};
    assign b_w   = {{DATA_W{b_ext}}, B};
    assign prod  = x_w * b_w;

    always_ff @(posedge clk) begin
        if (R) begin
            p_q <= '0;
            v1  <= 1'b0;
            f1  <= 1'b0;
        end else begin
            v1 <= valid_in;
            f1 <= valid_in & first_in;
            if (valid_in) begin
                p_q <= prod;
            end
        end
    end

    generate
        if (ACC_W > PW) begin : g_ext
            logic p_sign;
            assign p_sign = SGN & p_q[PW-1];
            assign p_ext  = {{(ACC_W-PW){p_sign}}, p_q};
        end else begin : g_noext
            assign p_ext = p_q;
        end
    endgenerate

    assign sum_w = {1'b0, y} + {1'b0, p_ext};

    always_comb begin
        ovf_now = 1'b0;
        sat_val = '1;
        if (SGN) begin
            ovf_now = (y[ACC_W-1] == p_ext[ACC_W-1]) &&
                      (sum_w[ACC_W-1] != y[ACC_W-1]);
            // Clamp toward the common sign of the two addends.
            sat_val = y[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf_now = sum_w[ACC_W];
        end
    end

`ifdef MAC_SAT_EN
    assign acc_nxt = ovf_now ? sat_val : sum_w[ACC_W-1:0];
`else
    assign acc_nxt = sum_w[ACC_W-1:0];
`endif

    assign cnt_nxt = (&acc_cnt) ? acc_cnt : acc_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (R) begin
            y         <= '0;
            valid_out <= 1'b0;
            acc_cnt   <= '0;
            ovf       <= 1'b0;
        end else begin
            valid_out <= v1;
            if (v1) begin
                if (f1) begin
                    y       <= p_ext;
                    acc_cnt <= CNT_W'(1);
                    ovf     <= 1'b0;
                end else begin
                    y       <= acc_nxt;
                    acc_cnt <= cnt_nxt;
                    ovf     <= ovf | ovf_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench for mac_pipe: unsigned default, signed, and 33-bit overflow instances.
module tb_mac_pipe;

    typedef struct {
        logic [63:0] y;
        int          cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        fin = 1'b0;
    logic        vin_u = 1'b0;
    logic        vin_s = 1'b0;
    logic        vin_o = 1'b0;
    logic [15:0] X = '0;
    logic [15:0] B = '0;

    logic [38:0] y_u;
    logic [38:0] y_s;
    logic [32:0] y_o;
    logic        vo_u, vo_s, vo_o;
    logic [7:0]  cnt_u, cnt_s, cnt_o;
    logic        ovf_u, ovf_s, ovf_o;

    exp_t q_u[$];
    exp_t q_s[$];
    exp_t q_o[$];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mac_pipe u_dut (
        .clk(clk), .R(R), .valid_in(vin_u), .first_in(fin),
        .X(X), .B(B), .y(y_u), .valid_out(vo_u),
        .acc_cnt(cnt_u), .ovf(ovf_u)
    );

    mac_pipe #(.SIGNED(1)) u_sgn (
        .clk(clk), .R(R), .valid_in(vin_s), .first_in(fin),
        .X(X), .B(B), .y(y_s), .valid_out(vo_s),
        .acc_cnt(cnt_s), .ovf(ovf_s)
    );

    mac_pipe #(.ACC_W(33)) u_ovf (
        .clk(clk), .R(R), .valid_in(vin_o), .first_in(fin),
        .X(X), .B(B), .y(y_o), .valid_out(vo_o),
        .acc_cnt(cnt_o), .ovf(ovf_o)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic term(input int sel, input logic [15:0] x,
                        input logic [15:0] b, input logic f,
                        input logic [63:0] ey, input int ecnt,
                        input logic eovf, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        X = x;
        B = b;
        fin = f;
        vin_u = (sel == 0);
        vin_s = (sel == 1);
        vin_o = (sel == 2);
        e.y = ey;
        e.cnt = ecnt;
        e.ovf = eovf;
        if (push) begin
            if (sel == 0) q_u.push_back(e);
            else if (sel == 1) q_s.push_back(e);
            else q_o.push_back(e);
        end
    endtask

    task automatic idle(input logic f);
        @(posedge clk);
        #1;
        vin_u = 1'b0;
        vin_s = 1'b0;
        vin_o = 1'b0;
        fin = f;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (vo_u) begin
            if (q_u.size() == 0) begin
                chk("u_extra_out", {25'd0, y_u}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q_u.pop_front();
                chk("u_y", {25'd0, y_u}, e.y);
                chk("u_cnt", {56'd0, cnt_u}, 64'(e.cnt));
                chk("u_ovf", {63'd0, ovf_u}, {63'd0, e.ovf});
            end
        end
        if (vo_s) begin
            if (q_s.size() == 0) begin
                chk("s_extra_out", {25'd0, y_s}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q_s.pop_front();
                chk("s_y", {25'd0, y_s}, e.y);
                chk("s_cnt", {56'd0, cnt_s}, 64'(e.cnt));
                chk("s_ovf", {63'd0, ovf_s}, {63'd0, e.ovf});
            end
        end
        if (vo_o) begin
            if (q_o.size() == 0) begin
                chk("o_extra_out", {31'd0, y_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q_o.pop_front();
                chk("o_y", {31'd0, y_o}, e.y);
                chk("o_cnt", {56'd0, cnt_o}, 64'(e.cnt));
                chk("o_ovf", {63'd0, ovf_o}, {63'd0, e.ovf});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ovf3;
`ifdef MAC_SAT_EN
        ovf3 = 64'd8589934591;
`else
        ovf3 = 64'd4294574083;
`endif
        repeat (3) @(posedge clk);
        #1;
        R = 1'b0;
        @(negedge clk);
        chk("rst_y", {25'd0, y_u}, 64'd0);
        chk("rst_vo", {63'd0, vo_u}, 64'd0);
        chk("rst_cnt", {56'd0, cnt_u}, 64'd0);
        chk("rst_ovf", {63'd0, ovf_u}, 64'd0);

        // legacy sequence, then idle with a stray first_in
        term(0, 16'd2, 16'd3, 1'b1, 64'd6, 1, 1'b0, 1'b1);
        term(0, 16'd5, 16'd4, 1'b0, 64'd26, 2, 1'b0, 1'b1);
        term(0, 16'd1, 16'd1, 1'b0, 64'd27, 3, 1'b0, 1'b1);
        term(0, 16'd16, 16'd3, 1'b0, 64'd75, 4, 1'b0, 1'b1);
        repeat (4) idle(1'b1);
        @(negedge clk);
        chk("hold_y", {25'd0, y_u}, 64'd75);
        chk("hold_vo", {63'd0, vo_u}, 64'd0);
        chk("hold_cnt", {56'd0, cnt_u}, 64'd4);

        // restart directly after a term
        term(0, 16'd2, 16'd3, 1'b1, 64'd6, 1, 1'b0, 1'b1);
        term(0, 16'd5, 16'd4, 1'b0, 64'd26, 2, 1'b0, 1'b1);
        term(0, 16'd7, 16'd7, 1'b1, 64'd49, 1, 1'b0, 1'b1);
        repeat (4) idle(1'b0);

        // reset the cycle after a valid term
        term(0, 16'd9, 16'd9, 1'b1, 64'd81, 1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        R = 1'b1;
        vin_u = 1'b0;
        fin = 1'b0;
        @(posedge clk);
        #1;
        R = 1'b0;
        @(negedge clk);
        chk("mid_y", {25'd0, y_u}, 64'd0);
        chk("mid_vo", {63'd0, vo_u}, 64'd0);
        chk("mid_cnt", {56'd0, cnt_u}, 64'd0);
        repeat (3) idle(1'b0);
        @(negedge clk);
        chk("mid_y2", {25'd0, y_u}, 64'd0);

        // gapped input: idle cycles must show no strobe and a held y
        term(0, 16'd3, 16'd3, 1'b1, 64'd9, 1, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("gap_vo0", {63'd0, vo_u}, 64'd0);
        chk("gap_y0", {25'd0, y_u}, 64'd0);
        term(0, 16'd2, 16'd2, 1'b0, 64'd13, 2, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("gap_vo1", {63'd0, vo_u}, 64'd0);
        chk("gap_y1", {25'd0, y_u}, 64'd9);
        term(0, 16'd1, 16'd4, 1'b0, 64'd17, 3, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("gap_vo2", {63'd0, vo_u}, 64'd0);
        chk("gap_y2", {25'd0, y_u}, 64'd13);
        repeat (4) idle(1'b0);

        // signed instance: -3*7 then +20
        term(1, 16'hFFFD, 16'd7, 1'b1, 64'h7F_FFFF_FFEB, 1, 1'b0, 1'b1);
        term(1, 16'd4, 16'd5, 1'b0, 64'h7F_FFFF_FFFF, 2, 1'b0, 1'b1);
        repeat (4) idle(1'b0);

        // 33-bit unsigned overflow, then restart clears ovf
        term(2, 16'hFFFF, 16'hFFFF, 1'b1, 64'd4294836225, 1, 1'b0, 1'b1);
        term(2, 16'hFFFF, 16'hFFFF, 1'b0, 64'd8589672450, 2, 1'b0, 1'b1);
        term(2, 16'hFFFF, 16'hFFFF, 1'b0, ovf3, 3, 1'b1, 1'b1);
        repeat (3) idle(1'b0);
        @(negedge clk);
        chk("ovf_sticky", {63'd0, ovf_o}, 64'd1);
        term(2, 16'd1, 16'd1, 1'b1, 64'd1, 1, 1'b0, 1'b1);
        repeat (5) idle(1'b0);
        @(negedge clk);

        chk("q_u_empty", 64'(q_u.size()), 64'd0);
        chk("q_s_empty", 64'(q_s.size()), 64'd0);
        chk("q_o_empty", 64'(q_o.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
